// File: rtl/sync_debounce_if.sv
// Signal bundle between a synchronised input source and the debouncer.
// The master side drives the raw sample and the counter clear.
// The slave side (the debouncer) returns the filtered level, the event pulses and the status.
interface sync_debounce_if #(
  parameter int CNT_W = 8
) ();
  logic             in_sync;
  logic             clr;
  logic             level;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] event_cnt;
  logic             busy;

  modport master (
    output in_sync,
    output clr,
    input  level,
    input  rise,
    input  fall,
    input  event_cnt,
    input  busy
  );

  modport slave (
    input  in_sync,
    input  clr,
    output level,
    output rise,
    output fall,
    output event_cnt,
    output busy
  );
endinterface

// File: rtl/sync_debounce.sv
// Debouncer for a single bit that is already synchronous to clk.
// A new level is accepted only after STABLE_CYCLES consecutive identical samples.
// On acceptance the block emits a one-cycle rise or fall pulse.
// Accepted rising edges are counted in a wrapping counter that software can clear.
module sync_debounce #(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic            clk,
  input  logic            reset,
  sync_debounce_if.slave  bus
);

  localparam int            CW         = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LO,
    WAIT_HI,
    IDLE_HI,
    WAIT_LO
  } state_t;

  state_t           stateReg;
  state_t           stateNext;
  logic [CW-1:0]    stabCnt;
  logic [CW-1:0]    stabCntNext;
  logic             levelReg;
  logic             levelNext;
  logic             riseReg;
  logic             riseNext;
  logic             fallReg;
  logic             fallNext;
  logic             busyReg;
  logic             busyNext;
  logic [CNT_W-1:0] eventCnt;
  logic [CNT_W-1:0] eventCntNext;

  // Qualification FSM: a candidate level must be seen on STABLE_CYCLES edges in a row, any opposite sample discards it
  always_comb begin
    stateNext   = stateReg;
    stabCntNext = stabCnt;
    levelNext   = levelReg;
    riseNext    = 1'b0;
    fallNext    = 1'b0;
    case (stateReg)
      IDLE_LO: begin
        if (bus.in_sync) begin
          stateNext   = WAIT_HI;
          stabCntNext = CW'(1);
        end
      end
      WAIT_HI: begin
        if (!bus.in_sync) begin
          stateNext   = IDLE_LO;
          stabCntNext = '0;
        end else if (stabCnt == LAST_COUNT) begin
          stateNext   = IDLE_HI;
          stabCntNext = '0;
          levelNext   = 1'b1;
          riseNext    = 1'b1;
        end else begin
          stabCntNext = stabCnt + CW'(1);
        end
      end
      IDLE_HI: begin
        if (!bus.in_sync) begin
          stateNext   = WAIT_LO;
          stabCntNext = CW'(1);
        end
      end
      WAIT_LO: begin
        if (bus.in_sync) begin
          stateNext   = IDLE_HI;
          stabCntNext = '0;
        end else if (stabCnt == LAST_COUNT) begin
          stateNext   = IDLE_LO;
          stabCntNext = '0;
          levelNext   = 1'b0;
          fallNext    = 1'b1;
        end else begin
          stabCntNext = stabCnt + CW'(1);
        end
      end
      default: begin
        stateNext   = IDLE_LO;
        stabCntNext = '0;
        levelNext   = 1'b0;
      end
    endcase
    busyNext = (stateNext == WAIT_HI) || (stateNext == WAIT_LO);
  end

  // Event counter update: a clear coinciding with an accepted rise still keeps that rise, so the count restarts at one
  always_comb begin
    eventCntNext = eventCnt;
    if (riseNext) begin
      eventCntNext = bus.clr ? CNT_W'(1) : eventCnt + CNT_W'(1);
    end else if (bus.clr) begin
      eventCntNext = '0;
    end
  end

  // State and registered outputs; reset drops any candidate in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg <= IDLE_LO;
      stabCnt  <= '0;
      levelReg <= 1'b0;
      riseReg  <= 1'b0;
      fallReg  <= 1'b0;
      busyReg  <= 1'b0;
      eventCnt <= '0;
    end else begin
      stateReg <= stateNext;
      stabCnt  <= stabCntNext;
      levelReg <= levelNext;
      riseReg  <= riseNext;
      fallReg  <= fallNext;
      busyReg  <= busyNext;
      eventCnt <= eventCntNext;
    end
  end

  assign bus.level     = levelReg;
  assign bus.rise      = riseReg;
  assign bus.fall      = fallReg;
  assign bus.busy      = busyReg;
  assign bus.event_cnt = eventCnt;

endmodule

// File: doc/sync_debounce.md
Name: sync_debounce

Overview:
Downstream consumer of the two-flop synchroniser output. It filters a synchronised, possibly bouncy single-bit input (push-button, external trigger, sensor strobe) into a clean debounced level. It also produces one-cycle rising and falling event pulses and keeps a wrapping count of debounced rising events for software/status readout. The input is already synchronous to clk, so this block adds no metastability handling.

Parameters:
STABLE_CYCLES, 16, consecutive identical samples required to accept a level change; legal range >= 2.
CNT_W, 8, width of the debounced rising-event counter.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_sync  input  1  synchronised raw input, from the synchroniser stage
clr  input  1  synchronous clear of event_cnt, active-high
level  output  1  debounced level
rise  output  1  one-cycle pulse on accepted 0->1 transition
fall  output  1  one-cycle pulse on accepted 1->0 transition
event_cnt  output  CNT_W  count of accepted rising transitions, wraps
busy  output  1  high while a candidate transition is being qualified

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE_LO, stability counter=0, level=0, rise=0, fall=0, event_cnt=0, busy=0. All outputs are registered.
- FSM states: IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO. Stability counter width is clog2(STABLE_CYCLES).
- IDLE_LO: in_sync=1 -> WAIT_HI, cnt=1. Otherwise stay.
- WAIT_HI:
  - in_sync=0 -> IDLE_LO, cnt=0, no pulse (glitch rejected).
  - in_sync=1 and cnt==STABLE_CYCLES-1 -> IDLE_HI, cnt=0, level=1, rise=1 for exactly one cycle.
  - Otherwise cnt+1.
- IDLE_HI / WAIT_LO mirror the above with polarity inverted. Acceptance sets level=0 and fall=1 for one cycle.
- Latency: level changes on the STABLE_CYCLES-th consecutive clock edge that samples the new value. The first such edge is the one that enters WAIT_*.
- busy=1 exactly when state is WAIT_HI or WAIT_LO (registered with the state).
- rise and fall are never high in the same cycle. Neither can repeat on consecutive cycles.
- event_cnt:
  - Increments by 1 in the cycle rise is asserted, modulo 2^CNT_W (all-ones -> 0).
  - clr=1 alone -> 0 next edge.
  - clr=1 in the same cycle as the increment -> 1 (the event is not lost).
- After reset release with in_sync already high: the block qualifies it normally and emits rise after STABLE_CYCLES edges. This is intentional.
- Reset asserted mid-qualification: the candidate is discarded. A full STABLE_CYCLES run is required after release.

Test Plan:
(All scenarios use STABLE_CYCLES=4, CNT_W=4.)
1. Release reset with in_sync=0, then hold in_sync=1 -> busy=1 on edges 1-3; level=1 and rise=1 at edge 4 only; event_cnt=1 at edge 4; busy=0 from edge 4.
2. From IDLE_LO, in_sync=1 for 3 cycles then 0 -> level stays 0, no rise, event_cnt=0, busy falls back to 0, state IDLE_LO.
3. From level=1, in_sync=0 held 4 cycles -> level=0 and fall=1 for one cycle at edge 4; event_cnt unchanged. A 1-cycle high bounce at sample 2 restarts qualification, so fall occurs 4 edges after the bounce ends.
4. Apply 16 clean debounced presses -> event_cnt steps 1..15 then 0 on the 16th rise.
5. clr=1 coincident with a rise at event_cnt=5 -> event_cnt=1. clr=1 with no rise -> event_cnt=0 next edge.
6. Pull reset=0 asynchronously in WAIT_HI at cnt=2 (mid-cycle) -> level/rise/busy/event_cnt go 0 immediately. After release with in_sync=1, rise occurs only after 4 fresh edges.
